// File: rtl/knn_list_ctrl.sv
// Sequencer for the KNN neighbour list: clears the list, streams candidates
// into it, then reads the K nearest entries out over a valid/ready port.
module knn_list_ctrl #(
  parameter int DATA_W = 32,
  parameter int LABEL  = 8,
  parameter int K      = 4,
  parameter int N_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_W-1:0]            n_train,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [DATA_W-1:0]         dist_in,
  input  logic [LABEL-1:0]          label_in,
  output logic                      list_clear,
  output logic                      list_start,
  output logic                      list_valid,
  output logic [DATA_W-1:0]         list_dist,
  output logic [LABEL-1:0]          list_label,
  output logic [$clog2(K)-1:0]      rd_idx,
  input  logic [DATA_W+LABEL-1:0]   rd_data,
  output logic                      nb_valid,
  input  logic                      nb_ready,
  output logic [DATA_W-1:0]         nb_dist,
  output logic [LABEL-1:0]          nb_label,
  output logic                      nb_last,
  output logic                      busy,
  output logic                      done
);

  localparam int KW = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [N_W-1:0]  r_remain;
  logic [KW-1:0]   r_rdIdx;
  logic            w_accept;
  logic            w_nbFire;
  logic            w_last;

  assign w_accept = (r_state == S_STREAM) && cand_valid;
  assign w_nbFire = (r_state == S_READ) && nb_ready;
  assign w_last   = (r_rdIdx == KW'(K - 1));
  assign rd_idx   = r_rdIdx;

  // STREAM leaves on the final accept, so the remaining count never wraps below zero.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nextState = S_CLEAR;
      S_CLEAR:  w_nextState = (r_remain != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_accept && (r_remain == N_W'(1))) w_nextState = S_DRAIN;
      S_DRAIN:  w_nextState = S_READ;
      S_READ:   if (w_nbFire && w_last) w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    cand_ready = 1'b0;
    list_clear = 1'b0;
    list_start = 1'b0;
    list_valid = 1'b0;
    list_dist  = '0;
    list_label = '0;
    nb_valid   = 1'b0;
    nb_dist    = '0;
    nb_label   = '0;
    nb_last    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_CLEAR: list_clear = 1'b1;
      S_STREAM: begin
        cand_ready = 1'b1;
        list_start = 1'b1;
        list_valid = cand_valid;
        list_dist  = dist_in;
        list_label = label_in;
      end
      S_READ: begin
        nb_valid = 1'b1;
        nb_dist  = rd_data[DATA_W+LABEL-1:LABEL];
        nb_label = rd_data[LABEL-1:0];
        nb_last  = w_last;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_rdIdx  <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE:   if (start) r_remain <= n_train;
        S_STREAM: if (w_accept) r_remain <= r_remain - N_W'(1);
        S_READ:   if (w_nbFire) r_rdIdx <= r_rdIdx + KW'(1);
        S_DONE:   r_rdIdx <= '0;
        default:  r_rdIdx <= r_rdIdx;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_list_ctrl.sv
// Bench for knn_list_ctrl: a behavioural sorted list feeds rd_data, and each
// run's neighbour output is compared with a sort-and-take-K reference model.
module tb_knn_list_ctrl;

  localparam int DATA_W = 32;
  localparam int LABEL  = 8;
  localparam int K      = 4;
  localparam int N_W    = 16;
  localparam int KW     = $clog2(K);
  localparam int BUDGET = 400;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [N_W-1:0]          n_train;
  logic                    cand_valid;
  logic                    cand_ready;
  logic [DATA_W-1:0]       dist_in;
  logic [LABEL-1:0]        label_in;
  logic                    list_clear;
  logic                    list_start;
  logic                    list_valid;
  logic [DATA_W-1:0]       list_dist;
  logic [LABEL-1:0]        list_label;
  logic [KW-1:0]           rd_idx;
  logic [DATA_W+LABEL-1:0] rd_data;
  logic                    nb_valid;
  logic                    nb_ready;
  logic [DATA_W-1:0]       nb_dist;
  logic [LABEL-1:0]        nb_label;
  logic                    nb_last;
  logic                    busy;
  logic                    done;

  knn_list_ctrl #(.DATA_W(DATA_W), .LABEL(LABEL), .K(K), .N_W(N_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_train(n_train),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .dist_in(dist_in), .label_in(label_in),
    .list_clear(list_clear), .list_start(list_start), .list_valid(list_valid),
    .list_dist(list_dist), .list_label(list_label),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .nb_valid(nb_valid), .nb_ready(nb_ready),
    .nb_dist(nb_dist), .nb_label(nb_label), .nb_last(nb_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [LABEL-1:0]  l;
  } ent_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [LABEL-1:0]  l;
    logic              last;
  } nb_t;

  typedef struct {
    int n;
    int vMode;
    int rMode;
    int noise;
    int expDone;
    int expFirstNb;
  } runVec_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t candQ[$];
  nb_t  gotQ[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural neighbour list: ascending by distance, ties keep arrival order.
  logic [DATA_W-1:0] lDist [K];
  logic [LABEL-1:0]  lLab  [K];
  int                insPos;

  assign rd_data = {lDist[rd_idx], lLab[rd_idx]};

  initial begin
    for (int k = 0; k < K; k++) begin
      lDist[k] = '1;
      lLab[k]  = '0;
    end
  end

  always @(posedge clk) begin
    if (list_clear) begin
      for (int k = 0; k < K; k++) begin
        lDist[k] = '1;
        lLab[k]  = '0;
      end
    end else if (list_valid) begin
      insPos = K;
      for (int k = K - 1; k >= 0; k--)
        if (list_dist < lDist[k]) insPos = k;
      if (insPos < K) begin
        for (int k = K - 1; k > insPos; k--) begin
          lDist[k] = lDist[k-1];
          lLab[k]  = lLab[k-1];
        end
        lDist[insPos] = list_dist;
        lLab[insPos]  = list_label;
      end
    end
  end

  // Cycle monitor: list strobe sanity, hold-under-backpressure, output capture.
  logic              prevStall = 1'b0;
  logic [DATA_W-1:0] prevDist;
  logic [LABEL-1:0]  prevLab;
  logic              prevLast;
  logic [KW-1:0]     prevIdx;

  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (list_valid) begin
        checkOutput("list_valid_needs_cand_valid", 64'(cand_valid), 64'd1);
        checkOutput("list_dist_pass", 64'(list_dist), 64'(dist_in));
        checkOutput("list_label_pass", 64'(list_label), 64'(label_in));
      end
      if (prevStall) begin
        checkOutput("nb_hold_valid", 64'(nb_valid), 64'd1);
        checkOutput("nb_hold_dist", 64'(nb_dist), 64'(prevDist));
        checkOutput("nb_hold_label", 64'(nb_label), 64'(prevLab));
        checkOutput("nb_hold_last", 64'(nb_last), 64'(prevLast));
        checkOutput("nb_hold_idx", 64'(rd_idx), 64'(prevIdx));
      end
      if (nb_valid && nb_ready) gotQ.push_back('{nb_dist, nb_label, nb_last});
      prevStall = nb_valid && !nb_ready;
      prevDist  = nb_dist;
      prevLab   = nb_label;
      prevLast  = nb_last;
      prevIdx   = rd_idx;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"},
                64'({cand_ready, list_clear, list_start, list_valid, nb_valid, nb_last, busy, done, rd_idx}), 64'd0);
    checkOutput({tag, "_list_data"}, 64'({list_dist, list_label}), 64'd0);
    checkOutput({tag, "_nb_data"}, 64'({nb_dist, nb_label}), 64'd0);
  endtask

  // Reference: K smallest of the candidates plus cleared padding, stable on ties.
  task automatic checkAgainstModel(input string tag, input int n);
    ent_t pool[$];
    ent_t expQ[$];
    int   best;
    for (int i = 0; i < n; i++) pool.push_back(candQ[i]);
    for (int i = 0; i < K; i++) pool.push_back('{'1, '0});
    for (int j = 0; j < K; j++) begin
      best = 0;
      for (int i = 1; i < pool.size(); i++)
        if (pool[i].d < pool[best].d) best = i;
      expQ.push_back(pool[best]);
      pool.delete(best);
    end
    checkOutput({tag, "_nb_count"}, 64'(gotQ.size()), 64'(K));
    for (int j = 0; j < K && j < gotQ.size(); j++) begin
      checkOutput($sformatf("%s_nb%0d_dist", tag, j), 64'(gotQ[j].d), 64'(expQ[j].d));
      checkOutput($sformatf("%s_nb%0d_label", tag, j), 64'(gotQ[j].l), 64'(expQ[j].l));
      checkOutput($sformatf("%s_nb%0d_last", tag, j), 64'(gotQ[j].last), 64'(j == K - 1));
    end
  endtask

  // One full run from start pulse to return to IDLE, cycle numbers relative to the start edge.
  task automatic applyStimulus(input runVec_t v, input string tag);
    int e, idx, accepts, reads, doneCyc, firstNb, lowCnt;
    bit finished, crSeen, busyOk, cv;
    gotQ.delete();
    @(posedge clk); #1;
    start   = 1'b1;
    n_train = N_W'(v.n);
    @(posedge clk); #1;
    start   = 1'b0;
    n_train = N_W'($urandom_range(1, 200));
    checkOutput({tag, "_clear_cycle1"}, 64'(list_clear), 64'd1);
    e = 0; idx = 0; accepts = 0; reads = 0; lowCnt = 0;
    doneCyc = -1; firstNb = -1;
    finished = 0; crSeen = 0; busyOk = 1;
    while (!finished && e < BUDGET) begin
      if (v.vMode == 0)      cv = 1'b1;
      else if (v.vMode == 1) cv = (e % 2) == 1;
      else                   cv = 1'($urandom_range(0, 1));
      cand_valid = (idx < v.n) ? cv : 1'b0;
      dist_in    = (idx < v.n) ? candQ[idx].d : DATA_W'($urandom);
      label_in   = (idx < v.n) ? candQ[idx].l : LABEL'($urandom);
      if (v.rMode == 0) nb_ready = 1'b1;
      else if (v.rMode == 1) begin
        nb_ready = !(reads == 1 && lowCnt < 3);
        if (!nb_ready) lowCnt++;
      end else nb_ready = 1'($urandom_range(0, 1));
      start = (v.noise != 0) && ((e == 3) || done);
      if (v.noise != 0) n_train = N_W'(1);
      @(posedge clk);
      e++;
      if (cand_valid && cand_ready) begin
        accepts++;
        idx++;
      end
      if (cand_ready) crSeen = 1;
      if (nb_valid && nb_ready) reads++;
      if (nb_valid && firstNb < 0) firstNb = e;
      if (!busy) busyOk = 0;
      if (done) begin
        doneCyc  = e;
        finished = 1;
      end
      #1;
    end
    start = 1'b0; cand_valid = 1'b0; nb_ready = 1'b0;
    checkOutput({tag, "_finished_in_budget"}, 64'(finished), 64'd1);
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    checkOutput({tag, "_busy_during"}, 64'(busyOk), 64'd1);
    checkOutput({tag, "_accepts"}, 64'(accepts), 64'(v.n));
    checkOutput({tag, "_reads"}, 64'(reads), 64'(K));
    if (v.n == 0) checkOutput({tag, "_cand_ready_seen"}, 64'(crSeen), 64'd0);
    if (v.expDone >= 0) checkOutput({tag, "_done_cycle"}, 64'(doneCyc), 64'(v.expDone));
    if (v.expFirstNb >= 0) checkOutput({tag, "_first_nb_cycle"}, 64'(firstNb), 64'(v.expFirstNb));
    checkAgainstModel(tag, v.n);
  endtask

  task automatic loadBasic(input int n);
    int bd[6] = '{50, 10, 40, 30, 20, 60};
    candQ.delete();
    for (int i = 0; i < n; i++) candQ.push_back('{DATA_W'(bd[i]), LABEL'(i + 1)});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    runVec_t vecs[5];
    int      expD[K] = '{10, 20, 30, 40};
    int      expL[K] = '{2, 5, 4, 3};
    runVec_t rv;
    int      c, guard;
    bit      doneSeen;

    vecs[0] = '{6, 0, 0, 0, 13, 9};
    vecs[1] = '{6, 1, 0, 0, -1, -1};
    vecs[2] = '{6, 0, 1, 0, 16, 9};
    vecs[3] = '{0, 0, 0, 0, 7, 3};
    vecs[4] = '{6, 0, 0, 1, 13, 9};

    rst = 1'b1; start = 1'b0; n_train = '0; cand_valid = 1'b0;
    dist_in = '0; label_in = '0; nb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      loadBasic(vecs[i].n);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 && gotQ.size() == K)
        for (int j = 0; j < K; j++) begin
          checkOutput($sformatf("basic_nb%0d_dist", j), 64'(gotQ[j].d), 64'(expD[j]));
          checkOutput($sformatf("basic_nb%0d_label", j), 64'(gotQ[j].l), 64'(expL[j]));
        end
    end

    // Reset after three accepted candidates aborts the run without a done pulse.
    loadBasic(6);
    @(posedge clk); #1;
    start = 1'b1; n_train = N_W'(6);
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; guard = 0;
    while (c < 3 && guard < 20) begin
      cand_valid = 1'b1;
      dist_in    = candQ[c].d;
      label_in   = candQ[c].l;
      @(posedge clk);
      guard++;
      if (cand_valid && cand_ready) c++;
      #1;
    end
    checkOutput("abort_accepts", 64'(c), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("abort_rst");
    rst = 1'b0; cand_valid = 1'b0;
    doneSeen = 0;
    repeat (20) begin
      @(posedge clk);
      if (done || busy) doneSeen = 1;
      #1;
    end
    checkOutput("abort_no_done_or_busy", 64'(doneSeen), 64'd0);
    applyStimulus('{6, 0, 0, 0, 13, 9}, "after_abort");

    for (int r = 0; r < 8; r++) begin
      rv.n = $urandom_range(0, 10);
      rv.vMode = $urandom_range(0, 2);
      rv.rMode = $urandom_range(0, 2);
      rv.noise = 0;
      rv.expDone = (rv.vMode == 0 && rv.rMode == 0) ? rv.n + K + 3 : -1;
      rv.expFirstNb = (rv.vMode == 0) ? rv.n + 3 : -1;
      candQ.delete();
      for (int i = 0; i < rv.n; i++)
        candQ.push_back('{DATA_W'($urandom_range(0, 1000)), LABEL'($urandom_range(0, 255))});
      applyStimulus(rv, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knn_list_ctrl.md
# knn_list_ctrl

Sequencer for the KNN neighbour-list datapath. For each test point it clears the K-entry sorted neighbour list, streams N training-point candidates (distance, label) from the distance unit into the list, then reads the K list entries out in ascending order over a valid/ready port. It sits between the distance unit and the result/vote logic and owns all list control strobes.

## Interface
- DATA_W, 32, distance width
- LABEL, 8, label width
- K, 4, neighbour-list depth (≥2); index width KW = $clog2(K)
- N_W, 16, training-count width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins one test-point run (sampled only in IDLE)
- n_train  in  N_W  number of candidates for this run, latched on accepted start
- cand_valid  in  1  candidate available from distance unit
- cand_ready  out  1  controller accepts candidate
- dist_in  in  DATA_W  candidate distance
- label_in  in  LABEL  candidate label
- list_clear  out  1  forces every list entry to {all-ones, 0}
- list_start  out  1  list enable level (inserts allowed)
- list_valid  out  1  insert strobe to list
- list_dist  out  DATA_W  candidate distance to list
- list_label  out  LABEL  candidate label to list
- rd_idx  out  KW  list entry select (0 = nearest)
- rd_data  in  DATA_W+LABEL  selected entry {dist, label}
- nb_valid  out  1  neighbour output valid
- nb_ready  in  1  consumer ready
- nb_dist  out  DATA_W  neighbour distance
- nb_label  out  LABEL  neighbour label
- nb_last  out  1  marks entry K-1
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, READ, DONE.
- IDLE: start=1 → latch n_train into remaining-count register, go CLEAR. Otherwise stay.
- CLEAR (1 cycle): list_clear=1. Next: STREAM if latched n_train≠0, else DRAIN.
- STREAM: cand_ready=1, list_start=1. Accept = cand_valid & cand_ready. On accept: list_valid=1 same cycle, list_dist=dist_in, list_label=label_in (combinational pass-through), decrement count. Accept with count==1 → DRAIN. cand_valid low → hold, no decrement.
- DRAIN (1 cycle): no strobes; lets the last list insertion settle.
- READ: nb_valid=1; rd_idx = read counter; {nb_dist, nb_label} = rd_data split MSB/LSB; nb_last = (rd_idx==K-1). On nb_valid&nb_ready: counter+1; if nb_last → DONE.
- DONE (1 cycle): done=1, counter cleared, → IDLE.
- Outside their states: cand_ready, list_*, nb_valid, nb_last = 0; list_dist/list_label/nb_dist/nb_label are don't-care but driven (no X).
- start outside IDLE ignored; n_train changes after latch ignored.
- n_train=0: list stays cleared; READ outputs K entries of {all-ones, 0}.
- Distance values are unsigned; controller performs no arithmetic on them.

## Timing
- Reset (sync, on clk edge with rst=1, from any state including mid-run): state=IDLE, counters=0, all outputs 0, rd_idx=0. No done pulse for an aborted run.
- busy=1 in CLEAR, STREAM, DRAIN, READ, DONE; 0 in IDLE.
- start accepted at edge t → list_clear high cycle t+1.
- Minimum run (cand_valid and nb_ready held high): 1 (CLEAR) + N + 1 (DRAIN) + K + 1 (DONE) cycles from start edge to return to IDLE; first nb_valid at cycle N+3 after start edge.
- Back-to-back: start asserted in the cycle after DONE is accepted (IDLE reached); start in the DONE cycle is dropped.
- nb_dist/nb_label/nb_last stable while nb_valid=1 and nb_ready=0.
- Counters: remaining count N_W bits, never underflows (STREAM exits on count==1); read counter KW bits, wraps to 0 in DONE.

## Test plan
- Basic: K=4, N=6, distances 50,10,40,30,20,60 labels 1..6, all valid/ready high → nb outputs (10,2),(20,5),(30,4),(40,3), nb_last on 4th, done pulse at cycle 13 after start.
- Sparse stream: same data with cand_valid toggling every other cycle → identical output; count decrements only on accepts; list_valid never high without cand_valid.
- Backpressure: nb_ready low for 3 cycles on entry 1 → nb_dist=20 held stable, rd_idx stays 1, no skipped/duplicated entries.
- n_train=0 → CLEAR then DRAIN, four outputs all-ones distance/label 0, done pulse, cand_ready never asserted.
- Reset mid-STREAM after 3 accepts → next cycle all outputs 0, busy 0, no done; new start runs fully correct.
- start pulsed during STREAM and during DONE → ignored; second start in IDLE begins new run with fresh n_train.
